// File: rtl/vTPU_pkg.sv
// Shared vTPU accumulator-path constants and types used by the skew buffer and its lane FIFOs.
package vTPU_pkg;

    localparam int Y_SCALED       = 4;
    localparam int ALPHA          = 4;
    localparam int ADD_DATAWIDTH  = 16;
    localparam int ACC_SKEW_DEPTH = 8;

    typedef logic [ALPHA*ADD_DATAWIDTH-1:0] acc_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } skew_state_e;

endpackage

// File: rtl/acc_lane_fifo.sv
// Single-lane synchronous FIFO for one accumulator row; no bypass, a full lane rejects pushes.
// With ACC_SKEW_OCC_EN defined the registered occupancy is exported on count_o.
module acc_lane_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
`ifdef ACC_SKEW_OCC_EN
    output logic [$clog2(DEPTH+1)-1:0] count_o,
`endif
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot for a push.
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok   = push_i && !full_o && !flush_i;
    assign pop_ok    = pop_i && !empty_o && !flush_i;
    assign rd_data_o = mem_q[rd_ptr_q];
`ifdef ACC_SKEW_OCC_EN
    assign count_o   = count_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/acc_skew_buffer.sv
// Per-lane accumulator buffering with a diagonal drain: lane r starts r cycles after lane 0.
// Optional macro ACC_SKEW_OCC_EN adds the lane_occ occupancy output.
module acc_skew_buffer #(
    parameter int Y_SCALED      = vTPU_pkg::Y_SCALED,
    parameter int ALPHA         = vTPU_pkg::ALPHA,
    parameter int ADD_DATAWIDTH = vTPU_pkg::ADD_DATAWIDTH,
    parameter int DEPTH         = vTPU_pkg::ACC_SKEW_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ALPHA*ADD_DATAWIDTH-1:0]   wr_data [0:Y_SCALED-1],
    input  logic [Y_SCALED-1:0]              wr_valid,
    output logic                             wr_ready,
    input  logic                             drain_req,
    input  logic [$clog2(DEPTH+1)-1:0]       burst_len,
    output logic [ALPHA*ADD_DATAWIDTH-1:0]   acc_out [0:Y_SCALED-1],
    output logic [Y_SCALED-1:0]              acc_out_valid,
    output logic                             drain_busy,
    output logic                             drain_done,
    output logic                             underflow_err,
`ifdef ACC_SKEW_OCC_EN
    output logic [$clog2(DEPTH+1)-1:0]       lane_occ [0:Y_SCALED-1],
`endif
    input  logic                             flush
);

    import vTPU_pkg::skew_state_e;
    import vTPU_pkg::IDLE;
    import vTPU_pkg::DRAIN;

    localparam int W  = ALPHA*ADD_DATAWIDTH;
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(Y_SCALED+1);

    skew_state_e         state_q, state_d;
    logic [CW-1:0]       len_q, len_d;
    logic [NW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       popped_q [Y_SCALED];
    logic [CW-1:0]       popped_d [Y_SCALED];
    logic [W-1:0]        acc_q [Y_SCALED];
    logic [W-1:0]        acc_d [Y_SCALED];
    logic [W-1:0]        rd_data [Y_SCALED];
    logic [Y_SCALED-1:0] valid_q, valid_d, pop, full, empty;
    logic                done_q, done_d, uflow_q, uflow_d;
    logic                flush_idle, all_done;

    assign flush_idle = flush && (state_q == IDLE);

    for (genvar r = 0; r < Y_SCALED; r++) begin : g_lane
        acc_lane_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush_i   (flush_idle),
            .push_i    (wr_valid[r]),
            .pop_i     (pop[r]),
            .wr_data_i (wr_data[r]),
            .rd_data_o (rd_data[r]),
            .full_o    (full[r]),
`ifdef ACC_SKEW_OCC_EN
            .count_o   (lane_occ[r]),
`endif
            .empty_o   (empty[r])
        );
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        popped_d = popped_q;
        acc_d    = acc_q;
        valid_d  = '0;
        done_d   = 1'b0;
        uflow_d  = uflow_q;
        pop      = '0;
        all_done = 1'b1;
        for (int r = 0; r < Y_SCALED; r++) begin
            if (popped_q[r] != len_q) all_done = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (drain_req && burst_len != '0) begin
                    state_d = DRAIN;
                    len_d   = burst_len;
                    cnt_d   = '0;
                    for (int r = 0; r < Y_SCALED; r++) popped_d[r] = '0;
                end
            end
            DRAIN: begin
                if (all_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (cnt_q != NW'(Y_SCALED)) cnt_d = cnt_q + NW'(1);
                    // A starved lane keeps retrying, stretching only its own skew.
                    for (int r = 0; r < Y_SCALED; r++) begin
                        if (cnt_q >= NW'(r) && popped_q[r] < len_q) begin
                            if (!empty[r]) begin
                                pop[r]      = 1'b1;
                                acc_d[r]    = rd_data[r];
                                valid_d[r]  = 1'b1;
                                popped_d[r] = popped_q[r] + CW'(1);
                            end else begin
                                uflow_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int r = 0; r < Y_SCALED; r++) begin
            if (wr_valid[r] && full[r]) uflow_d = 1'b1;
        end
        if (flush_idle) uflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            uflow_q <= 1'b0;
            for (int r = 0; r < Y_SCALED; r++) begin
                popped_q[r] <= '0;
                acc_q[r]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            uflow_q  <= uflow_d;
            popped_q <= popped_d;
            acc_q    <= acc_d;
        end
    end

    assign wr_ready      = ~|full;
    assign acc_out       = acc_q;
    assign acc_out_valid = valid_q;
    assign drain_busy    = (state_q == DRAIN);
    assign drain_done    = done_q;
    assign underflow_err = uflow_q;

endmodule
